// File: rtl/debug_dump_sequencer_if.sv
// debug_dump_sequencer_if: dump request, word fetch and UART byte handshake
interface debug_dump_sequencer_if #(parameter int ADDR_BITS = 6) ();
  logic                 dump_req;
  logic [31:0]          word_data;
  logic [ADDR_BITS-1:0] word_addr;
  logic                 tx_done_tick;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 busy;
  logic                 dump_done;
  modport master (output dump_req, word_data, tx_done_tick, input word_addr, tx_start, tx_data, busy, dump_done);
  modport slave (input dump_req, word_data, tx_done_tick, output word_addr, tx_start, tx_data, busy, dump_done);
endinterface

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: streams a framed, XOR-checksummed dump of debug words to a byte UART
module debug_dump_sequencer #(
  parameter int         NUM_WORDS = 40,
  parameter int         ADDR_BITS = 6,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic                   clk,
  input logic                   rst,
  debug_dump_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, LOAD, SEND, WAIT, CSUM, DONE} state_t;
  typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_CSUM} phase_t;
  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(NUM_WORDS - 1);
  state_t               state_q, state_d;
  phase_t               phase_q, phase_d;
  logic [1:0]           byte_q, byte_d;
  logic [ADDR_BITS-1:0] word_addr_q, word_addr_d;
  logic [31:0]          shift_q, shift_d;
  logic [7:0]           csum_q, csum_d, tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d, busy_q, busy_d, dump_done_q, dump_done_d;
  // next state; outputs are precomputed from the next state so they are valid in the state itself
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    byte_d      = byte_q;
    word_addr_d = word_addr_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: if (bus.dump_req) begin
        state_d     = HDR;
        phase_d     = PH_HDR;
        busy_d      = 1'b1;
        word_addr_d = '0;
        byte_d      = '0;
        csum_d      = '0;
      end
      HDR:  state_d = WAIT;
      LOAD: begin
        shift_d = bus.word_data;
        state_d = SEND;
      end
      SEND: begin
        csum_d  = csum_q ^ shift_q[31:24];
        phase_d = PH_DATA;
        state_d = WAIT;
      end
      WAIT: if (bus.tx_done_tick) begin
        if (phase_q == PH_HDR) state_d = LOAD;
        else if (phase_q == PH_CSUM) begin
          state_d = DONE;
          busy_d  = 1'b0;
        end else if (byte_q != 2'd3) begin
          shift_d = shift_q << 8;
          byte_d  = byte_q + 2'd1;
          state_d = SEND;
        end else if (word_addr_q != LAST) begin
          word_addr_d = word_addr_q + 1'b1;
          byte_d      = '0;
          state_d     = LOAD;
        end else begin
          phase_d = PH_CSUM;
          state_d = CSUM;
        end
      end
      CSUM: state_d = WAIT;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_start_d  = state_d inside {HDR, SEND, CSUM};
    dump_done_d = state_d == DONE;
    tx_data_d   = (state_d == HDR) ? SYNC_BYTE : (state_d == SEND) ? shift_d[31:24] : (state_d == CSUM) ? csum_d : tx_data_q;
  end
  // state and registered outputs; reset aborts any frame in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= PH_HDR;
      byte_q      <= '0;
      word_addr_q <= '0;
      shift_q     <= '0;
      csum_q      <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      dump_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      byte_q      <= byte_d;
      word_addr_q <= word_addr_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      busy_q      <= busy_d;
      dump_done_q <= dump_done_d;
    end
  end
  assign bus.word_addr = word_addr_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = busy_q;
  assign bus.dump_done = dump_done_q;
endmodule
